nibble_rx: RTL and testbench

NIBBLE_RX -- requirements
Module: nibble_rx

---
 rtl/nibble_rx.sv | 91 +++++++++
 tb/tb_nibble_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_rx.sv
// Two-entry elastic receive buffer with a running modulo sum of every accepted word.
// The head entry drives out directly, so an accepted word is never bypassed to out in the same cycle.
//
// state | meaning
// EMPTY | no word buffered, out holds its last value
// ONE   | head entry valid
// FULL  | head and tail entries valid, upstream stalled
module nibble_rx #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic [1:0]       level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             accept, deliver;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out       = mem_q[0];
  assign acc       = acc_q;
  assign level     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      mem_q   <= '{default: '0};
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    acc_d   = acc_q;
    accept  = in_valid && in_ready;
    deliver = out_valid && out_ready;

    // in is only ever read under accept, so X on an idle bus cannot leak out
    if (accept) acc_d = acc_q + in;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          mem_d[0] = in;
          state_d  = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          mem_d[0] = in;
        end else if (accept) begin
          mem_d[1] = in;
          state_d  = FULL;
        end else if (deliver) begin
          state_d  = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          mem_d[0] = mem_q[1];
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_nibble_rx.sv
// Bench for nibble_rx: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_nibble_rx;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out;
  logic         out_ready = 1'b0;
  logic [W-1:0] acc;
  logic [1:0]   level;

  int total = 0;
  int bad = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] acc_m = '0;

  nibble_rx #(.WIDTH(W), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in(in), .in_ready(in_ready),
    .out_valid(out_valid), .out(out), .out_ready(out_ready),
    .acc(acc), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: level is the queue size, out is the queue front, acc a plain sum.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        acc_m = '0;
      end
      check("m_in_ready", int'(in_ready), int'(q.size() < 2));
      check("m_out_valid", int'(out_valid), int'(q.size() > 0));
      check("m_level", int'(level), q.size());
      check("m_acc", int'(acc), int'(acc_m));
      if (q.size() > 0) check("m_out", int'(out), int'(q[0]));
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        acc_m = '0;
      end else begin
        logic acc_ev, del_ev;
        acc_ev = in_valid && (q.size() < 2);
        del_ev = out_ready && (q.size() > 0);
        if (del_ev) void'(q.pop_front());
        if (acc_ev) begin
          q.push_back(in);
          acc_m = W'(int'(acc_m) + int'(in));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_acc", int'(acc), 0);
    check("rst_out", int'(out), 0);
    do_reset();

    // single accept, no deliver
    in_valid = 1'b1; in = 4'h5;
    cyc();
    in_valid = 1'b0;
    check("one_out_valid", int'(out_valid), 1);
    check("one_out", int'(out), 5);
    check("one_level", int'(level), 1);
    check("one_acc", int'(acc), 5);
    check("one_in_ready", int'(in_ready), 1);

    // fill, stall, drain
    do_reset();
    in_valid = 1'b1; in = 4'h3;
    cyc();
    in = 4'h9;
    cyc();
    in = 4'hA;
    check("full_level", int'(level), 2);
    check("full_in_ready", int'(in_ready), 0);
    check("full_acc", int'(acc), 12);
    cyc();
    check("stall_acc", int'(acc), 12);
    check("stall_out", int'(out), 3);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    check("drain1_out", int'(out), 9);
    check("drain1_level", int'(level), 1);
    cyc();
    check("drain2_out_valid", int'(out_valid), 0);
    check("drain2_acc", int'(acc), 12);
    out_ready = 1'b0;

    // streaming in ONE
    do_reset();
    in_valid = 1'b1; in = 4'h1;
    cyc();
    check("stream_out_1", int'(out), 1);
    out_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      in = W'(k);
      cyc();
      check("stream_out", int'(out), k);
      check("stream_level", int'(level), 1);
    end
    in_valid = 1'b0;
    cyc();
    check("stream_empty", int'(out_valid), 0);
    out_ready = 1'b0;

    // accumulator wrap
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in = 4'hF;
    cyc();
    check("wrap_acc_f", int'(acc), 15);
    in = 4'h1;
    cyc();
    check("wrap_acc_0", int'(acc), 0);
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0;

    // async reset while FULL
    in_valid = 1'b1; in = 4'h6;
    cyc();
    in = 4'h7;
    cyc();
    in_valid = 1'b0;
    check("pre_rst_level", int'(level), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", int'(level), 0);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out", int'(out), 0);
    check("arst_acc", int'(acc), 0);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("post_rst_out_valid", int'(out_valid), 0);
    check("post_rst_acc", int'(acc), 0);
    cyc();
    check("post_rst_no_deliver", int'(out_valid), 0);
    out_ready = 1'b0;

    // random stress; idle data bus driven with X
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in        = in_valid ? W'($urandom_range(0, 15)) : 'x;
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    check("final_empty", int'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
